inv_round_unit: RTL and testbench
=================================

# inv_round_unit

Sequential inverse-cipher linear-layer engine for the vector decryption path. It undoes the linear steps of one forward AES round (AddRoundKey, MixColumns, ShiftRows) on a 128-bit state, processing one column per cycle through a shared InvMixColumns datapath. Input and output use valid/ready handshakes. The inverse S-box stage sits downstream in the decrypt pipeline.

## Interface
- No parameters. Data width is fixed at 128 bits.
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  state_in, round_key and skip_mix are valid.
- in_ready  output  1  block can accept a new state.
- state_in  input  128  ciphertext/intermediate state, row-major: row r = bits [127-32r -: 32]; byte (r,c) = bits [127-32r-8c -: 8].
- round_key  input  128  round key, same row-major layout.
- skip_mix  input  1  1 = bypass InvMixColumns (final-round form).
- out_valid  output  1  state_out holds a finished result.
- out_ready  input  1  downstream accepts state_out.
- state_out  output  128  result, row-major layout.
- busy  output  1  high in any state other than IDLE.

## Operation
- The FSM has four states: IDLE, MIX, SHIFT, DONE.
- **IDLE:** in_ready = 1. An accept occurs when in_valid && in_ready at an edge. On accept:
  - state_reg <= state_in ^ round_key.
  - skip_mix is latched into mode_reg.
  - col <= 0.
  - Next state is SHIFT if skip_mix = 1, else MIX.
- **MIX:** each cycle replaces column col of state_reg with InvMixColumns(column), then col++. After col = 3, go to SHIFT. col wraps to 0.
- **InvMixColumns:** for a column (a0..a3), GF(2^8) arithmetic with polynomial 0x11B:
  - o0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - o1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - o2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - o3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
  - Build it from xtime chains. No multiplier and no table.
- **SHIFT:** one cycle applies InvShiftRows: new (r,c) = old (r,(c−r) mod 4), i.e. row r rotates right by 8r bits. Then go to DONE.
- **DONE:** out_valid = 1 and state_out = state_reg, both held stable until out_ready. On out_valid && out_ready, go to IDLE.
- state_out is driven from state_reg at all times. It is only meaningful while out_valid = 1.
- round_key, state_in and skip_mix are sampled only at the accept edge. Later changes have no effect.
- in_valid is ignored outside IDLE. There is no queuing.
- The block has no error conditions. All 128-bit inputs are legal.

## Timing
- **Reset:**
  - FSM = IDLE, state_reg = 0, col = 0, mode_reg = 0.
  - Outputs after reset: out_valid = 0, busy = 0, state_out = 0, in_ready = 1.
  - While rst is high, no accept and no output handshake occurs.
- **Reset mid-operation** (any state, including DONE with out_ready low): the next edge returns the block to the reset values. The in-flight result is discarded and out_valid never pulses for it.
- **Latency, mix path:** the accept edge is E0. MIX occupies E1..E4, SHIFT is E5, and out_valid = 1 in the cycle after E5.
- **Latency, skip path:** SHIFT is E1, and out_valid = 1 in the cycle after E1.
- **Throughput:** with out_ready held at 1, the mix path sees an accept every 7 cycles and the skip path every 3 cycles. out_ready is allowed to be high before out_valid.
- **Back-to-back operation:** in_ready returns to 1 in the cycle after the output handshake. The block never accepts in the same cycle as its output handshake.
- **Backpressure:** DONE persists indefinitely. While waiting, state_out and out_valid are stable and in_ready = 0.

## Test plan
- **Reset values:** assert rst 3 cycles → out_valid = 0, busy = 0, state_out = 0, in_ready = 1. Pulse in_valid during rst → no accept.
- **InvMixColumns:**
  - Stimulus: state_in = 8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc, key = 0, skip_mix = 0.
  - Expected: state_out = dbdbdbdb_13131313_53535353_45454545, with out_valid rising exactly 6 cycles after the accept edge.
  - Repeat with uniform columns 9fdc589d → f20a225c.
  - Repeat with uniform columns 01010101 → unchanged.
- **Key add before mix:** state_in = 0, round_key = 8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc, skip_mix = 0 → state_out = dbdbdbdb_13131313_53535353_45454545.
- **Skip path and InvShiftRows:**
  - Stimulus: state_in = 00010203_04050607_08090a0b_0c0d0e0f, key = 0, skip_mix = 1.
  - Expected: state_out = 00010203_07040506_0a0b0809_0d0e0f0c, with out_valid rising 2 cycles after the accept.
- **Backpressure:**
  - Hold out_ready = 0 for 10 cycles after out_valid → state_out stable, in_ready = 0, and an in_valid pulse is ignored.
  - Then raise out_ready for 1 cycle → out_valid drops and in_ready = 1 on the next cycle.
- **Reset mid-operation:** assert rst during MIX (col = 2) → the next cycle is IDLE with state_out = 0. A subsequent transaction completes with the correct result.

Source files
------------

// File: rtl/inv_round_unit.sv
// inv_round_unit
//
// Inverse linear layer of one AES round for the vector decryption path. An accepted state
// has the round key added, then (unless skip_mix is set) InvMixColumns is applied one
// column per cycle through a single shared datapath, followed by InvShiftRows in one cycle.
// The inverse S-box is applied downstream.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   state_in / round_key / skip_mix valid
//   in_ready   block idle and able to accept
//   state_in   128-bit state, row-major: byte (r,c) = bits [127-32r-8c -: 8]
//   round_key  128-bit round key, same layout
//   skip_mix   1 = final-round form (no InvMixColumns)
//   out_valid  state_out holds a finished result
//   out_ready  downstream accepts state_out
//   state_out  128-bit result, row-major
//   busy       high in any state other than idle

module inv_round_unit (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         skip_mix,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StMix, StShift, StDone} st_e;

    st_e          st_q, st_d;
    logic [127:0] state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic         mode_q, mode_d;

    // Multiply by x (02) in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns on one column {a0,a1,a2,a3}; coefficients built from x2/x4/x8 chains.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    logic [31:0]  col_sel;
    logic [31:0]  col_mixed;
    logic [127:0] state_mixed;
    logic [127:0] state_shifted;

    // Column select / write-back for the shared mix datapath.
    always_comb begin
        col_sel     = '0;
        state_mixed = state_q;
        for (int c = 0; c < 4; c++) begin
            if (col_q == 2'(c)) begin
                for (int r = 0; r < 4; r++) begin
                    col_sel[31-8*r -: 8] = state_q[127-32*r-8*c -: 8];
                end
            end
        end
        col_mixed = inv_mix_col(col_sel);
        for (int c = 0; c < 4; c++) begin
            if (col_q == 2'(c)) begin
                for (int r = 0; r < 4; r++) begin
                    state_mixed[127-32*r-8*c -: 8] = col_mixed[31-8*r -: 8];
                end
            end
        end
    end

    // InvShiftRows: new (r,c) takes old (r,(c-r) mod 4), i.e. row r rotates right by r bytes.
    always_comb begin
        state_shifted = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                state_shifted[127-32*r-8*c -: 8] = state_q[127-32*r-8*((c-r+4)%4) -: 8];
            end
        end
    end

    always_comb begin
        st_d    = st_q;
        state_d = state_q;
        col_d   = col_q;
        mode_d  = mode_q;
        case (st_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = state_in ^ round_key;
                    mode_d  = skip_mix;
                    col_d   = 2'd0;
                    st_d    = skip_mix ? StShift : StMix;
                end
            end
            StMix: begin
                state_d = state_mixed;
                col_d   = col_q + 2'd1;
                // mode_q can only be clear here; treat a set bit as "leave mix now".
                if (col_q == 2'd3 || mode_q) begin
                    st_d = StShift;
                end
            end
            StShift: begin
                state_d = state_shifted;
                st_d    = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    st_d = StIdle;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= StIdle;
            state_q <= '0;
            col_q   <= 2'd0;
            mode_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            col_q   <= col_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready  = (st_q == StIdle);
    assign out_valid = (st_q == StDone);
    assign busy      = (st_q != StIdle);
    assign state_out = state_q;

endmodule

// File: tb/tb_inv_round_unit.sv
module tb_inv_round_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] round_key;
    logic         skip_mix;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    always #5 clk = ~clk;

    inv_round_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .round_key (round_key),
        .skip_mix  (skip_mix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    logic [127:0] exp_q[$];
    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Generic shift-and-add GF(2^8) multiply, modulus 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                           input logic skip);
        logic [7:0]   b[4][4];
        logic [7:0]   a[4];
        logic [127:0] x;
        logic [127:0] o;
        x = s ^ k;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) b[r][c] = x[127-32*r-8*c -: 8];
        if (!skip) begin
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) a[r] = b[r][c];
                b[0][c] = gmul(a[0], 8'h0e) ^ gmul(a[1], 8'h0b) ^ gmul(a[2], 8'h0d) ^ gmul(a[3], 8'h09);
                b[1][c] = gmul(a[0], 8'h09) ^ gmul(a[1], 8'h0e) ^ gmul(a[2], 8'h0b) ^ gmul(a[3], 8'h0d);
                b[2][c] = gmul(a[0], 8'h0d) ^ gmul(a[1], 8'h09) ^ gmul(a[2], 8'h0e) ^ gmul(a[3], 8'h0b);
                b[3][c] = gmul(a[0], 8'h0b) ^ gmul(a[1], 8'h0d) ^ gmul(a[2], 8'h09) ^ gmul(a[3], 8'h0e);
            end
        end
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) o[127-32*r-8*c -: 8] = b[r][(c-r+4)%4];
        return o;
    endfunction

    // One full transaction: accept, wait for out_valid (bounded), optionally hold
    // backpressure for 'hold' cycles, then complete the output handshake.
    task automatic run_txn(input string tag, input logic [127:0] s, input logic [127:0] k,
                           input logic skip, input logic [127:0] exp, input int hold);
        logic [127:0] want;
        int lat;
        exp_q.push_back(exp);
        check({tag, ".in_ready_pre"}, 128'(in_ready), 128'(1));
        in_valid  = 1'b1;
        state_in  = s;
        round_key = k;
        skip_mix  = skip;
        step();
        // Inputs after the accept edge must not matter.
        in_valid  = 1'b0;
        state_in  = rand128();
        round_key = rand128();
        skip_mix  = ~skip;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({tag, ".latency"}, 128'(lat), skip ? 128'(1) : 128'(5));
        want = exp_q.pop_front();
        check({tag, ".data"}, state_out, want);
        check({tag, ".busy"}, 128'(busy), 128'(1));
        check({tag, ".in_ready_busy"}, 128'(in_ready), 128'(0));
        for (int h = 0; h < hold; h++) begin
            in_valid = (h == 3);
            state_in = rand128();
            step();
            check({tag, ".hold_data"}, state_out, want);
            check({tag, ".hold_valid"}, 128'(out_valid), 128'(1));
            check({tag, ".hold_in_ready"}, 128'(in_ready), 128'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, ".post_valid"}, 128'(out_valid), 128'(0));
        check({tag, ".post_in_ready"}, 128'(in_ready), 128'(1));
        check({tag, ".post_busy"}, 128'(busy), 128'(0));
    endtask

    initial begin
        logic [127:0] s, k;
        logic         sk;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
        round_key = '0;
        skip_mix  = 1'b0;

        // Reset held 3 cycles with in_valid pulsing: nothing may be accepted.
        for (int i = 0; i < 3; i++) begin
            in_valid = (i == 1);
            state_in = 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef;
            step();
        end
        check("rst.out_valid", 128'(out_valid), 128'(0));
        check("rst.busy", 128'(busy), 128'(0));
        check("rst.state_out", state_out, 128'h0);
        check("rst.in_ready", 128'(in_ready), 128'(1));
        in_valid = 1'b0;
        rst      = 1'b0;
        step();
        check("rst.no_accept_busy", 128'(busy), 128'(0));
        check("rst.no_accept_state", state_out, 128'h0);

        run_txn("mix8e", 128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc, 128'h0, 1'b0,
                128'hdbdbdbdb_13131313_53535353_45454545, 0);
        run_txn("mix9f", 128'h9f9f9f9f_dcdcdcdc_58585858_9d9d9d9d, 128'h0, 1'b0,
                128'hf2f2f2f2_0a0a0a0a_22222222_5c5c5c5c, 0);
        run_txn("mix01", {4{32'h01010101}}, 128'h0, 1'b0, {4{32'h01010101}}, 0);
        run_txn("keyadd", 128'h0, 128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc, 1'b0,
                128'hdbdbdbdb_13131313_53535353_45454545, 0);
        run_txn("skip", 128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h0, 1'b1,
                128'h00010203_07040506_0a0b0809_0d0e0f0c, 0);
        run_txn("bp", 128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc, 128'h0, 1'b0,
                128'hdbdbdbdb_13131313_53535353_45454545, 10);

        // Reset during MIX with col = 2.
        in_valid  = 1'b1;
        state_in  = rand128();
        round_key = rand128();
        skip_mix  = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst.busy", 128'(busy), 128'(0));
        check("midrst.state_out", state_out, 128'h0);
        check("midrst.out_valid", 128'(out_valid), 128'(0));
        check("midrst.in_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("midrst.no_pulse", 128'(out_valid), 128'(0));
        end
        out_ready = 1'b0;
        run_txn("after_rst", 128'h00010203_04050607_08090a0b_0c0d0e0f,
                128'h0f0e0d0c_0b0a0908_07060504_03020100, 1'b0,
                model(128'h00010203_04050607_08090a0b_0c0d0e0f,
                      128'h0f0e0d0c_0b0a0908_07060504_03020100, 1'b0), 0);

        // Random traffic against the reference model.
        for (int i = 0; i < 6; i++) begin
            s  = rand128();
            k  = rand128();
            sk = (i % 3 == 2);
            run_txn("rand", s, k, sk, model(s, k, sk), i % 2);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
